code_lock: RTL and testbench

CODE_LOCK -- requirements
Module: code_lock

---
 rtl/code_lock.sv | 155 +++++++++++++++
 tb/tb_code_lock.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock.sv
// code_lock: serial combination lock.
//
// Bits arrive one per accepted clock (b_valid=1) MSB-first and are shifted
// into an attempt register. After CODE_LEN bits the attempt is compared with
// CODE: a match opens the lock, a mismatch bumps the consecutive-failure
// count, and reaching MAX_FAIL failures locks the block out for
// LOCKOUT_CYCLES clocks. All state changes on the falling edge of clk.
//
// Ports
//   clk      in   clock, state updates on negedge
//   clear    in   asynchronous active-low reset
//   b_valid  in   qualifies b_in
//   b_in     in   serial code bit
//   relock   in   close the lock / abort a partial attempt
//   unlock   out  1 while OPEN
//   lockout  out  1 while LOCKOUT
//   busy     out  1 while COLLECT holds a partial attempt
//   fail_cnt out  consecutive failed attempts
module code_lock #(
    parameter int                  CODE_LEN       = 6,
    parameter logic [CODE_LEN-1:0] CODE           = 6'b101100,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             clear,
    input  logic                             b_valid,
    input  logic                             b_in,
    input  logic                             relock,
    output logic                             unlock,
    output logic                             lockout,
    output logic                             busy,
    output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int CW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [CW-1:0] LAST_BIT   = CW'(CODE_LEN - 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAIL);
    localparam logic [FW:0]   FAIL_MAX_X = (FW + 1)'(MAX_FAIL);

    typedef enum logic [1:0] {
        S_COLLECT = 2'b00,
        S_OPEN    = 2'b01,
        S_LOCKOUT = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [CODE_LEN-1:0]   attempt_q, attempt_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FW-1:0]         fail_q, fail_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  unlock_q, lockout_q, busy_q;

    logic [CODE_LEN-1:0]   shifted;
    logic [FW:0]           fail_inc;

    always_comb begin
        state_d   = state_q;
        attempt_d = attempt_q;
        cnt_d     = cnt_q;
        fail_d    = fail_q;
        timer_d   = timer_q;

        // Attempt including the bit offered on this edge; for CODE_LEN=1 the
        // shift drops everything and only b_in remains.
        shifted  = (attempt_q << 1) | CODE_LEN'(b_in);
        // One extra bit so the increment cannot wrap before the compare.
        fail_inc = {1'b0, fail_q} + (FW + 1)'(1);

        case (state_q)
            S_COLLECT: begin
                if (relock) begin
                    cnt_d     = '0;
                    attempt_d = '0;
                end else if (b_valid) begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_d     = '0;
                        attempt_d = '0;
                        if (shifted == CODE) begin
                            state_d = S_OPEN;
                            fail_d  = '0;
                        end else if (fail_inc == FAIL_MAX_X) begin
                            state_d = S_LOCKOUT;
                            fail_d  = FAIL_MAX;
                            timer_d = TIMER_LOAD;
                        end else begin
                            fail_d  = fail_inc[FW-1:0];
                        end
                    end else begin
                        cnt_d     = cnt_q + CW'(1);
                        attempt_d = shifted;
                    end
                end
            end
            S_OPEN: begin
                if (relock) begin
                    state_d   = S_COLLECT;
                    cnt_d     = '0;
                    attempt_d = '0;
                end
            end
            S_LOCKOUT: begin
                // Timer was loaded with LOCKOUT_CYCLES-1, so leaving on the
                // zero edge keeps lockout high for exactly LOCKOUT_CYCLES.
                if (timer_q == '0) begin
                    state_d = S_COLLECT;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d   = S_COLLECT;
                attempt_d = '0;
                cnt_d     = '0;
                fail_d    = '0;
                timer_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they change on
    // the same edge as the state they describe.
    always_ff @(negedge clk or negedge clear) begin
        if (!clear) begin
            state_q   <= S_COLLECT;
            attempt_q <= '0;
            cnt_q     <= '0;
            fail_q    <= '0;
            timer_q   <= '0;
            unlock_q  <= 1'b0;
            lockout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            attempt_q <= attempt_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            timer_q   <= timer_d;
            unlock_q  <= (state_d == S_OPEN);
            lockout_q <= (state_d == S_LOCKOUT);
            busy_q    <= (state_d == S_COLLECT) && (cnt_d != '0);
        end
    end

    assign unlock   = unlock_q;
    assign lockout  = lockout_q;
    assign busy     = busy_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_code_lock.sv
// Bench for code_lock: three instances with different parameter sets, driven
// by directed sequences and random stimulus, compared every cycle against a
// behavioural model of the lock rules.
module tb_code_lock;

    localparam int NI = 3;

    int p_len  [NI] = '{6, 4, 1};
    int p_code [NI] = '{44, 6, 1};   // 101100, 0110, 1
    int p_maxf [NI] = '{3, 2, 1};
    int p_lock [NI] = '{16, 5, 1};

    logic clk   = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    logic bv [NI];
    logic bi [NI];
    logic rl [NI];
    logic unl [NI];
    logic lko [NI];
    logic bsy [NI];
    logic [1:0] fc0;
    logic [1:0] fc1;
    logic [0:0] fc2;

    code_lock u0 (
        .clk(clk), .clear(clear), .b_valid(bv[0]), .b_in(bi[0]), .relock(rl[0]),
        .unlock(unl[0]), .lockout(lko[0]), .busy(bsy[0]), .fail_cnt(fc0)
    );
    code_lock #(.CODE_LEN(4), .CODE(4'b0110), .MAX_FAIL(2), .LOCKOUT_CYCLES(5)) u1 (
        .clk(clk), .clear(clear), .b_valid(bv[1]), .b_in(bi[1]), .relock(rl[1]),
        .unlock(unl[1]), .lockout(lko[1]), .busy(bsy[1]), .fail_cnt(fc1)
    );
    code_lock #(.CODE_LEN(1), .CODE(1'b1), .MAX_FAIL(1), .LOCKOUT_CYCLES(1)) u2 (
        .clk(clk), .clear(clear), .b_valid(bv[2]), .b_in(bi[2]), .relock(rl[2]),
        .unlock(unl[2]), .lockout(lko[2]), .busy(bsy[2]), .fail_cnt(fc2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: collected bits as an integer, bit count, failures, and the
    // number of lockout cycles still to be served (0 = not locked out).
    int m_bits  [NI];
    int m_nbits [NI];
    int m_fail  [NI];
    int m_lock  [NI];
    bit m_open  [NI];

    function automatic int dut_fc(input int i);
        case (i)
            0:       return int'(fc0);
            1:       return int'(fc1);
            default: return int'(fc2);
        endcase
    endfunction

    task automatic check(input string nm, input int i, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, i, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_bits[i] = 0; m_nbits[i] = 0; m_fail[i] = 0; m_lock[i] = 0; m_open[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            if (m_lock[i] > 0) begin
                m_lock[i]--;
                if (m_lock[i] == 0) m_fail[i] = 0;
            end else if (m_open[i]) begin
                if (rl[i]) begin
                    m_open[i] = 0; m_nbits[i] = 0; m_bits[i] = 0;
                end
            end else if (rl[i]) begin
                m_nbits[i] = 0; m_bits[i] = 0;
            end else if (bv[i]) begin
                m_bits[i] = m_bits[i] * 2 + (bi[i] ? 1 : 0);
                m_nbits[i]++;
                if (m_nbits[i] == p_len[i]) begin
                    if (m_bits[i] == p_code[i]) begin
                        m_open[i] = 1; m_fail[i] = 0;
                    end else begin
                        m_fail[i]++;
                        if (m_fail[i] == p_maxf[i]) m_lock[i] = p_lock[i];
                    end
                    m_bits[i] = 0; m_nbits[i] = 0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk or negedge clear);
            if (!clear) model_reset();
            else model_step();
        end
    end

    // Outputs are stable at the rising edge (state moves on the falling edge).
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                check("unlock",   i, int'(unl[i]), int'(m_open[i]));
                check("lockout",  i, int'(lko[i]), (m_lock[i] > 0) ? 1 : 0);
                check("busy",     i, int'(bsy[i]),
                      (!m_open[i] && m_lock[i] == 0 && m_nbits[i] > 0) ? 1 : 0);
                check("fail_cnt", i, dut_fc(i), m_fail[i]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int i, input int b);
        bv[i] = 1'b1;
        bi[i] = (b != 0);
        tick();
        bv[i] = 1'b0;
    endtask

    task automatic send_code(input int i, input int val, input int len);
        for (int k = len - 1; k >= 0; k--) send(i, (val >> k) & 1);
    endtask

    task automatic do_relock(input int i);
        rl[i] = 1'b1;
        tick();
        rl[i] = 1'b0;
    endtask

    function automatic logic want_bit(input int i);
        return ((p_code[i] >> (p_len[i] - 1 - m_nbits[i])) & 1) != 0;
    endfunction

    int cnt;
    int guard;

    initial begin
        for (int i = 0; i < NI; i++) begin
            bv[i] = 1'b0; bi[i] = 1'b0; rl[i] = 1'b0;
        end
        tick(); tick();
        check("rst_unlock",  0, int'(unl[0]), 0);
        check("rst_lockout", 0, int'(lko[0]), 0);
        check("rst_busy",    0, int'(bsy[0]), 0);
        check("rst_fail",    0, dut_fc(0), 0);
        clear = 1'b1;
        tick();

        // Correct code, then relock.
        send(0, 1); send(0, 0); send(0, 1); send(0, 1); send(0, 0);
        check("busy_mid", 0, int'(bsy[0]), 1);
        check("unlock_early", 0, int'(unl[0]), 0);
        send(0, 0);
        check("open", 0, int'(unl[0]), 1);
        check("open_fail", 0, dut_fc(0), 0);
        do_relock(0);
        check("relocked", 0, int'(unl[0]), 0);

        // Gap of idle cycles inside an attempt.
        send(0, 1); send(0, 0); send(0, 1);
        repeat (5) tick();
        check("busy_gap", 0, int'(bsy[0]), 1);
        send(0, 1); send(0, 0); send(0, 0);
        check("open_gap", 0, int'(unl[0]), 1);
        do_relock(0);

        // Three wrong attempts -> lockout for 16 cycles, input ignored.
        send_code(0, 0, 6);
        check("fail1", 0, dut_fc(0), 1);
        send_code(0, 0, 6);
        check("fail2", 0, dut_fc(0), 2);
        send_code(0, 0, 6);
        check("lock_on", 0, int'(lko[0]), 1);
        check("lock_fail", 0, dut_fc(0), 3);
        cnt = 1;
        guard = 0;
        while (guard < 100) begin
            bv[0] = 1'b1;
            bi[0] = want_bit(0) ^ 1'b0;
            bi[0] = ((44 >> (5 - (guard % 6))) & 1) != 0;
            rl[0] = (guard == 3);
            tick();
            guard++;
            if (lko[0]) cnt++;
            else break;
        end
        bv[0] = 1'b0; rl[0] = 1'b0;
        check("lock_len", 0, cnt, 16);
        check("lock_ignored", 0, int'(unl[0]), 0);
        check("lock_exit_fail", 0, dut_fc(0), 0);
        send_code(0, 44, 6);
        check("open_after_lock", 0, int'(unl[0]), 1);
        do_relock(0);

        // Two failures then success clears the count.
        send_code(0, 63, 6);
        send_code(0, 63, 6);
        check("fail_two", 0, dut_fc(0), 2);
        send_code(0, 44, 6);
        check("open_two", 0, int'(unl[0]), 1);
        check("open_two_fail", 0, dut_fc(0), 0);
        do_relock(0);

        // Relock beats b_valid and keeps the failure count.
        send_code(0, 0, 6);
        send(0, 1); send(0, 0); send(0, 1);
        bv[0] = 1'b1; bi[0] = 1'b1; rl[0] = 1'b1;
        tick();
        bv[0] = 1'b0; rl[0] = 1'b0;
        check("abort_busy", 0, int'(bsy[0]), 0);
        check("abort_fail", 0, dut_fc(0), 1);
        send_code(0, 44, 6);
        check("abort_open", 0, int'(unl[0]), 1);
        do_relock(0);

        // Single-bit attempts.
        send(2, 0);
        check("l1_lock", 2, int'(lko[2]), 1);
        check("l1_fail", 2, dut_fc(2), 1);
        tick();
        check("l1_unlock_lock", 2, int'(lko[2]), 0);
        send(2, 1);
        check("l1_open", 2, int'(unl[2]), 1);
        check("l1_busy", 2, int'(bsy[2]), 0);

        // Asynchronous clear during lockout.
        send_code(1, 0, 4);
        send_code(1, 0, 4);
        check("i1_lock", 1, int'(lko[1]), 1);
        check("i1_fail", 1, dut_fc(1), 2);
        tick();
        #1 clear = 1'b0;
        #1;
        check("clr_lockout", 1, int'(lko[1]), 0);
        check("clr_fail",    1, dut_fc(1), 0);
        check("clr_open2",   2, int'(unl[2]), 0);
        #1 clear = 1'b1;
        send_code(1, 6, 4);
        check("i1_open", 1, int'(unl[1]), 1);
        do_relock(1);

        // Random traffic biased toward the right code bits.
        repeat (3000) begin
            for (int i = 0; i < NI; i++) begin
                rl[i] = ($urandom_range(15) == 0);
                bv[i] = 1'($urandom_range(1));
                if ($urandom_range(3) != 0) bi[i] = want_bit(i);
                else bi[i] = 1'($urandom_range(1));
            end
            if ($urandom_range(499) == 0) begin
                #1 clear = 1'b0;
                #1 clear = 1'b1;
            end
            tick();
        end
        for (int i = 0; i < NI; i++) begin
            bv[i] = 1'b0; rl[i] = 1'b0;
        end
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
